spi_rom_line_fetch: RTL
=======================

Name: spi_rom_line_fetch

Overview:
- Parametrised SPI flash READ engine for the VGA ROM-display path; replaces hpos-decoded SPI sequencing with a self-timed FSM started by a strobe.
- Issues command, address and optional dummy cycles, then receives DATA_BITS bits.
- In direct mode each received bit is streamed out immediately; in store mode bits fill an internal line buffer that the pixel path drains later, e.g. during the next visible line.

Parameters:
- DATA_BITS, 120, bits read per transaction (8..1024).
- ADDR_W, 24, address bits sent MSB-first.
- CMD, 8'h03, read opcode sent MSB-first.
- DUMMY, 0, dummy SCLK cycles between address and data.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- store  in  1  mode latched with start: 0 = direct stream, 1 = fill line buffer.
- addr  in  ADDR_W  flash address, latched with start.
- busy  out  1  high from the cycle after start until done.
- done  out  1  one-cycle pulse when the transaction ends.
- spi_cs  out  1  chip enable, ACTIVE HIGH (external inverter).
- spi_sclk  out  1  continuously ~clk.
- spi_mosi  out  1  serial command/address out.
- spi_miso  in  1  serial data in.
- rx_bit  out  1  direct-mode received bit.
- rx_valid  out  1  rx_bit strobe, one cycle per bit.
- buf_bit  out  1  line buffer MSB.
- buf_shift  in  1  shift line buffer left by one, zero-fill.
- buf_full  out  1  buffer holds a complete line not yet fully drained.

Behaviour:
- Reset (async): state IDLE, spi_cs=0, spi_mosi=0, busy=0, done=0, rx_valid=0, rx_bit=0, buf_full=0, buffer=0. Reset mid-transaction drops spi_cs immediately; no partial data is flagged.
- FSM states: IDLE -> CMD(8) -> ADDR(ADDR_W) -> DUMMY(DUMMY, skipped if 0) -> DATA(DATA_BITS) -> IDLE. One down-counter sized for max(8, ADDR_W, DUMMY, DATA_BITS) is reloaded on each transition.
- Cycle numbering: T0 is the posedge where start=1 in IDLE. At T1: spi_cs<=1, mosi<=CMD[7], busy<=1, and addr/store are latched.
- MOSI changes on posedge clk, so the slave samples on the rising edge of spi_sclk. CMD occupies T1..T8, ADDR T9..T(8+ADDR_W), DUMMY follows. MOSI=0 in DUMMY and DATA.
- Data bit k (MSB first) is driven by the flash during cycle Td+k, where Td = 9+ADDR_W+DUMMY. It is captured on negedge clk into miso_q and consumed at the posedge of Td+k+1.
- Direct mode: rx_bit=miso_q and rx_valid=1 registered at posedge Td+k+1, for k = 0..DATA_BITS-1. No other outputs are affected.
- Store mode: the buffer shifts in miso_q at the same posedges. After the last bit, buf_full<=1.
- End of transaction: at posedge Td+DATA_BITS, spi_cs<=0, busy<=0, done<=1 for one cycle. With defaults this is T153.
- start while busy: ignored, with no queueing.
- buf_shift rules:
  - Ignored while a store transaction is busy; the fill owns the buffer.
  - Otherwise it shifts left with 0 in.
  - buf_full clears after DATA_BITS shifts, tracked by a drain counter.
- A new store start while buf_full=1 is allowed: it overwrites the buffer and clears buf_full at T1.
- A direct-mode transaction never modifies the buffer or buf_full.
- Counter widths use $clog2 of the largest phase length plus 1. No wrap occurs within a phase.

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined: CMD is forced to 8'h0B and DUMMY to 8, overriding the parameters. With defaults, Td=41 and done occurs at T161.
- Undefined: the CMD and DUMMY parameters are used as given.

Decomposition:
- Shared package vga_spi_pkg holds:
  - FSM state enum (IDLE, CMD, ADDR, DUMMY, DATA);
  - opcode constants SPI_CMD_READ=8'h03 and SPI_CMD_FAST_READ=8'h0B;
  - fast-read dummy count 8.
- One sub-module, spi_line_buffer: DATA_BITS shift register with fill and drain ports, drain counter and buf_full.

Test Plan:
1. Defaults, start with addr=24'h000150, store=0 -> MOSI T1..T32 = 0000_0011 then 0x000150 MSB-first; spi_cs high T1..T152; flash model data 8'hA5... produces rx_bit 1,0,1,0,0,1,0,1 with rx_valid at T34..T41; done at T153 only.
2. Store mode, start with addr=0 and model data pattern -> no rx_valid; buf_full at T153; 120 buf_shift pulses return the pattern on buf_bit MSB-first; buf_full clears after the 120th shift.
3. start pulses at T5 and T100 during a transaction -> ignored; exactly one done; spi_cs stays high with no glitch.
4. reset asserted at T60 of a store transaction -> spi_cs=0 and busy=0 asynchronously; buf_full=0; a subsequent start runs normally.
5. buf_shift held high during a store fill -> buffer contents are not corrupted and match model data exactly.
6. SPI_FAST_READ_EN defined -> MOSI opcode 0000_1011; 8 dummy cycles with MOSI=0; first rx_valid at T42; done at T161.

Source files
------------

// File: rtl/vga_spi_pkg.sv
// Shared definitions for the VGA ROM-display SPI path.
// Contents:
//   spi_state_e          - read-engine FSM states
//   SPI_CMD_READ         - standard READ opcode (8'h03)
//   SPI_CMD_FAST_READ    - FAST READ opcode (8'h0B)
//   SPI_FAST_READ_DUMMY  - dummy SCLK cycles required by FAST READ
//   max4()               - largest of four phase lengths, used to size counters
package vga_spi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD   = 3'd1,
        ST_ADDR  = 3'd2,
        ST_DUMMY = 3'd3,
        ST_DATA  = 3'd4
    } spi_state_e;

    localparam logic [7:0] SPI_CMD_READ        = 8'h03;
    localparam logic [7:0] SPI_CMD_FAST_READ   = 8'h0B;
    localparam int         SPI_FAST_READ_DUMMY = 8;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_line_buffer.sv
// Line buffer for the SPI ROM line fetch: a DATA_BITS shift register that is
// filled MSB-first by the read engine and drained MSB-first by the pixel path.
// Ports:
//   clk, reset    - clock, asynchronous active-high reset
//   i_clear       - a new store transaction is starting: drop buf_full
//   i_fill_en     - shift i_fill_bit in at the LSB
//   i_fill_bit    - received data bit
//   i_fill_last   - this fill is the final bit of the line
//   i_fill_busy   - a store transaction owns the buffer; drain shifts ignored
//   i_shift       - drain request: shift left, zero-fill
//   o_msb         - buffer MSB
//   o_full        - complete line present and not yet fully drained
module spi_line_buffer
#(
    parameter int DATA_BITS = 120
)(
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_fill_en,
    input  logic i_fill_bit,
    input  logic i_fill_last,
    input  logic i_fill_busy,
    input  logic i_shift,
    output logic o_msb,
    output logic o_full
);

    localparam int DW = $clog2(DATA_BITS) + 1;

    logic [DATA_BITS-1:0] r_line;
    logic [DW-1:0]        r_drain;
    logic                 r_full;

    // Fill has priority over drain; drain shifts only count while a full line is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line  <= {DATA_BITS{1'b0}};
            r_drain <= {DW{1'b0}};
            r_full  <= 1'b0;
        end else if (i_clear) begin
            r_full  <= 1'b0;
            r_drain <= {DW{1'b0}};
        end else if (i_fill_en) begin
            r_line <= {r_line[DATA_BITS-2:0], i_fill_bit};
            if (i_fill_last) begin
                r_full  <= 1'b1;
                r_drain <= {DW{1'b0}};
            end
        end else if (i_shift && !i_fill_busy) begin
            r_line <= {r_line[DATA_BITS-2:0], 1'b0};
            if (r_full) begin
                if (r_drain == DW'(DATA_BITS - 1)) begin
                    r_full  <= 1'b0;
                    r_drain <= {DW{1'b0}};
                end else begin
                    r_drain <= r_drain + DW'(1);
                end
            end
        end
    end

    assign o_msb  = r_line[DATA_BITS-1];
    assign o_full = r_full;

endmodule

// File: rtl/spi_rom_line_fetch.sv
// Self-timed SPI flash READ engine for the VGA ROM-display path. A one-cycle
// start in IDLE sends the opcode and address MSB-first, optional dummy
// cycles, then receives DATA_BITS bits, either streamed out on rx_bit/rx_valid
// (store=0) or collected into a line buffer drained later via buf_shift (store=1).
// Optional build macro: SPI_FAST_READ_EN forces opcode 8'h0B and 8 dummy cycles.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   start, store, addr  - request, mode and flash address (latched together)
//   busy, done          - transaction in progress / one-cycle completion pulse
//   spi_cs              - active-high chip enable (inverted externally)
//   spi_sclk            - ~clk, so the slave samples MOSI mid-cycle
//   spi_mosi, spi_miso  - serial out / serial in
//   rx_bit, rx_valid    - direct-mode bit stream
//   buf_bit, buf_shift  - line buffer MSB / drain shift request
//   buf_full            - line buffer holds an undrained line
module spi_rom_line_fetch
    import vga_spi_pkg::*;
#(
    parameter int         DATA_BITS = 120,
    parameter int         ADDR_W    = 24,
    parameter logic [7:0] CMD       = 8'h03,
    parameter int         DUMMY     = 0
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              store,
    input  logic [ADDR_W-1:0] addr,
    output logic              busy,
    output logic              done,
    output logic              spi_cs,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic              rx_bit,
    output logic              rx_valid,
    output logic              buf_bit,
    input  logic              buf_shift,
    output logic              buf_full
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] EFF_CMD   = SPI_CMD_FAST_READ;
    localparam int         EFF_DUMMY = SPI_FAST_READ_DUMMY;
`else
    localparam logic [7:0] EFF_CMD   = CMD;
    localparam int         EFF_DUMMY = DUMMY;
`endif

    localparam int MAXLEN = max4(8, ADDR_W, EFF_DUMMY, DATA_BITS);
    localparam int CW     = $clog2(MAXLEN) + 1;
    localparam int TXW    = 8 + ADDR_W;

    spi_state_e      r_state;
    logic [CW-1:0]   r_cnt;
    logic [TXW-1:0]  r_tx;
    logic            r_store;
    logic            r_cs;
    logic            r_mosi;
    logic            r_busy;
    logic            r_done;
    logic            r_rx_bit;
    logic            r_rx_valid;
    logic            r_miso_q;

    logic            w_cnt_zero;
    logic            w_clear;
    logic            w_fill_en;
    logic            w_fill_last;
    logic            w_fill_busy;

    assign w_cnt_zero = (r_cnt == {CW{1'b0}});

    // MISO is launched by the flash on the falling SCLK edge; capture it mid-cycle.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_miso_q <= 1'b0;
        end else begin
            r_miso_q <= spi_miso;
        end
    end

    // Read-engine FSM: one down-counter reloaded at every phase change.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cnt      <= {CW{1'b0}};
            r_tx       <= {TXW{1'b0}};
            r_store    <= 1'b0;
            r_cs       <= 1'b0;
            r_mosi     <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rx_bit   <= 1'b0;
            r_rx_valid <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_CMD;
                        r_cnt   <= CW'(7);
                        // Opcode MSB goes out now; the rest queues behind it.
                        r_mosi  <= EFF_CMD[7];
                        r_tx    <= {EFF_CMD[6:0], addr, 1'b0};
                        r_cs    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_store <= store;
                    end
                end
                ST_CMD: begin
                    r_mosi <= r_tx[TXW-1];
                    r_tx   <= {r_tx[TXW-2:0], 1'b0};
                    if (w_cnt_zero) begin
                        r_state <= ST_ADDR;
                        r_cnt   <= CW'(ADDR_W - 1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_ADDR: begin
                    if (w_cnt_zero) begin
                        r_mosi <= 1'b0;
                        if (EFF_DUMMY > 0) begin
                            r_state <= ST_DUMMY;
                            r_cnt   <= CW'(EFF_DUMMY - 1);
                        end else begin
                            r_state <= ST_DATA;
                            r_cnt   <= CW'(DATA_BITS - 1);
                        end
                    end else begin
                        r_mosi <= r_tx[TXW-1];
                        r_tx   <= {r_tx[TXW-2:0], 1'b0};
                        r_cnt  <= r_cnt - CW'(1);
                    end
                end
                ST_DUMMY: begin
                    r_mosi <= 1'b0;
                    if (w_cnt_zero) begin
                        r_state <= ST_DATA;
                        r_cnt   <= CW'(DATA_BITS - 1);
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_DATA: begin
                    // Each edge here consumes the bit captured on the preceding falling edge.
                    r_mosi <= 1'b0;
                    if (!r_store) begin
                        r_rx_bit   <= r_miso_q;
                        r_rx_valid <= 1'b1;
                    end
                    if (w_cnt_zero) begin
                        r_state <= ST_IDLE;
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cs    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_mosi  <= 1'b0;
                end
            endcase
        end
    end

    assign w_clear     = (r_state == ST_IDLE) && start && store;
    assign w_fill_en   = (r_state == ST_DATA) && r_store;
    assign w_fill_last = w_fill_en && w_cnt_zero;
    assign w_fill_busy = r_busy && r_store;

    spi_line_buffer #(
        .DATA_BITS (DATA_BITS)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        .i_clear     (w_clear),
        .i_fill_en   (w_fill_en),
        .i_fill_bit  (r_miso_q),
        .i_fill_last (w_fill_last),
        .i_fill_busy (w_fill_busy),
        .i_shift     (buf_shift),
        .o_msb       (buf_bit),
        .o_full      (buf_full)
    );

    assign busy     = r_busy;
    assign done     = r_done;
    assign spi_cs   = r_cs;
    assign spi_sclk = ~clk;
    assign spi_mosi = r_mosi;
    assign rx_bit   = r_rx_bit;
    assign rx_valid = r_rx_valid;

endmodule
